// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage program-counter generator.
// Holds the FSM state and trap-cause encodings plus the alignment helper.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    EXT      = 2'd1,
    MISALIGN = 2'd2
  } pc_cause_t;

  localparam int ILEN_BYTES = 4;

  // With 16-bit instructions only bit 0 must be clear; otherwise the low two bits.
  function automatic logic is_misaligned(input logic [1:0] lsbs, input int ialign);
    if (ialign == 16) begin
      return lsbs[0];
    end
    return (lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch/control bundle between the control unit, instruction memory and pc_gen.
// master drives the requests and handshake, slave is the PC generator itself.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  import pc_pkg::*;

  logic            fetch_ready;
  logic            stall;
  logic            branch_taken;
  logic            jump;
  logic            jalr;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic            halt_req;
  logic            resume;
  logic            trap_req;

  logic [XLEN-1:0] pc;
  logic            fetch_valid;
  logic [XLEN-1:0] pc_link;
  logic            trap_taken;
  logic [XLEN-1:0] epc;
  pc_cause_t       cause;

  modport master (
    output fetch_ready, stall, branch_taken, jump, jalr, imm, rs1,
           halt_req, resume, trap_req,
    input  pc, fetch_valid, pc_link, trap_taken, epc, cause
  );

  modport slave (
    input  fetch_ready, stall, branch_taken, jump, jalr, imm, rs1,
           halt_req, resume, trap_req,
    output pc, fetch_valid, pc_link, trap_taken, epc, cause
  );

endinterface

// File: rtl/pc_gen_target_calc.sv
// Combinational redirect-target calculation: pc-relative and jalr targets,
// priority selection between them and the misaligned-target flag.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_branch,
  input  logic            i_jump,
  input  logic            i_jalr,
  output logic [XLEN-1:0] o_target,
  output logic            o_redirect,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_pcRelTarget;
  logic [XLEN-1:0] w_jalrSum;
  logic [XLEN-1:0] w_jalrTarget;

  assign w_pcRelTarget = i_pc + i_imm;
  assign w_jalrSum     = i_rs1 + i_imm;
  assign w_jalrTarget  = w_jalrSum & ~XLEN'(1);

  // jump and branch share the pc+imm target, so only jalr needs to override it.
  always_comb begin
    o_target = w_pcRelTarget;
    if (i_jalr) begin
      o_target = w_jalrTarget;
    end
  end

  assign o_redirect   = i_jalr | i_jump | i_branch;
  assign o_misaligned = o_redirect && is_misaligned(o_target[1:0], IALIGN);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sole owner of the architectural PC,
// with fetch handshake, halt/resume, jumps/branches and trap redirection.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              IALIGN       = 32
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  pc_state_t       r_state;
  pc_state_t       w_stateNext;
  pc_cause_t       r_cause;
  pc_cause_t       w_causeNext;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pcNext;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] w_epcNext;
  logic            r_trapTaken;
  logic            w_trapNext;
  logic            r_rstSync;

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pcSeq;
  logic            w_redirect;
  logic            w_misaligned;
  logic            w_fetchValid;
  logic            w_accept;

  assign w_fetchValid = (r_state == RUN);
  assign w_accept     = w_fetchValid && bus.fetch_ready && !bus.stall;
  assign w_pcSeq      = r_pc + XLEN'(ILEN_BYTES);

  pc_target_calc #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_targetCalc (
    .i_pc         (r_pc),
    .i_imm        (bus.imm),
    .i_rs1        (bus.rs1),
    .i_branch     (bus.branch_taken),
    .i_jump       (bus.jump),
    .i_jalr       (bus.jalr),
    .o_target     (w_target),
    .o_redirect   (w_redirect),
    .o_misaligned (w_misaligned)
  );

  // Priority mux: trap, then misaligned redirect, then redirect/sequential, else hold.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_epcNext   = r_epc;
    w_causeNext = r_cause;
    w_trapNext  = 1'b0;

    case (r_state)
      BOOT: begin
        if (r_rstSync) begin
          w_stateNext = RUN;
        end
      end

      RUN, HALT: begin
        if (bus.trap_req) begin
          w_epcNext   = r_pc;
          w_causeNext = EXT;
          w_pcNext    = TRAP_VECTOR;
          w_trapNext  = 1'b1;
          w_stateNext = RUN;
        end else if (r_state == HALT) begin
          if (bus.resume) begin
            w_stateNext = RUN;
          end
        end else if (w_accept && w_misaligned) begin
          w_epcNext   = r_pc;
          w_causeNext = MISALIGN;
          w_pcNext    = TRAP_VECTOR;
          w_trapNext  = 1'b1;
          w_stateNext = RUN;
        end else begin
          if (w_accept) begin
            w_pcNext = w_redirect ? w_target : w_pcSeq;
          end
          if (bus.halt_req) begin
            w_stateNext = HALT;
          end
        end
      end

      default: begin
        w_stateNext = BOOT;
      end
    endcase
  end

  // r_rstSync keeps BOOT for a full cycle after the edge that sees reset released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= BOOT;
      r_pc        <= RESET_VECTOR;
      r_epc       <= '0;
      r_cause     <= NONE;
      r_trapTaken <= 1'b0;
      r_rstSync   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_pc        <= w_pcNext;
      r_epc       <= w_epcNext;
      r_cause     <= w_causeNext;
      r_trapTaken <= w_trapNext;
      r_rstSync   <= 1'b1;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.fetch_valid = w_fetchValid;
  assign bus.pc_link     = w_pcSeq;
  assign bus.trap_taken  = r_trapTaken;
  assign bus.epc         = r_epc;
  assign bus.cause       = r_cause;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: per-scenario tasks drive step tables, push the
// expected PC/trap state to a scoreboard queue and compare it after each clock edge.
module tb_pc_gen;
  import pc_pkg::*;

  localparam logic [7:0] C_RDY = 8'h01;
  localparam logic [7:0] C_STL = 8'h02;
  localparam logic [7:0] C_BR  = 8'h04;
  localparam logic [7:0] C_JMP = 8'h08;
  localparam logic [7:0] C_JR  = 8'h10;
  localparam logic [7:0] C_HLT = 8'h20;
  localparam logic [7:0] C_RES = 8'h40;
  localparam logic [7:0] C_TRP = 8'h80;

  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] xPc;
    logic        xValid;
    logic        xFull;
    logic        xTrap;
    logic [31:0] xEpc;
    logic [1:0]  xCause;
  } step_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checkCount = 0;
  int    passCount  = 0;
  step_t expQ[$];

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32)) bus ();

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .IALIGN       (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic step_t mk(input logic [7:0] ctl, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic [31:0] xPc,
                               input logic xValid);
    step_t s;
    s.ctl = ctl; s.imm = imm; s.rs1 = rs1; s.xPc = xPc; s.xValid = xValid;
    s.xFull = 1'b0; s.xTrap = 1'b0; s.xEpc = '0; s.xCause = 2'd0;
    return s;
  endfunction

  function automatic step_t mkT(input logic [7:0] ctl, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] xPc,
                                input logic xValid, input logic xTrap,
                                input logic [31:0] xEpc, input logic [1:0] xCause);
    step_t s;
    s = mk(ctl, imm, rs1, xPc, xValid);
    s.xFull = 1'b1; s.xTrap = xTrap; s.xEpc = xEpc; s.xCause = xCause;
    return s;
  endfunction

  task automatic applyStimulus(input step_t s);
    bus.fetch_ready  = s.ctl[0];
    bus.stall        = s.ctl[1];
    bus.branch_taken = s.ctl[2];
    bus.jump         = s.ctl[3];
    bus.jalr         = s.ctl[4];
    bus.halt_req     = s.ctl[5];
    bus.resume       = s.ctl[6];
    bus.trap_req     = s.ctl[7];
    bus.imm          = s.imm;
    bus.rs1          = s.rs1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t steps[$];
    step_t e;
    rst = 1'b0;
    applyStimulus(mk(8'h00, 32'h0, 32'h0, 32'h0, 1'b0));
    repeat (2) tick();
    expQ.push_back(mkT(8'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd0));
    e = expQ.pop_front();
    checkCount++;
    if ({bus.fetch_valid, bus.pc, bus.trap_taken, bus.epc, bus.cause} !==
        {e.xValid, e.xPc, e.xTrap, e.xEpc, e.xCause})
      $display("[TB] FAIL reset_state got v=%b pc=%h t=%b epc=%h c=%0d want v=0 pc=0 t=0 epc=0 c=0",
               bus.fetch_valid, bus.pc, bus.trap_taken, bus.epc, bus.cause);
    else passCount++;
    rst = 1'b1;
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0000, 1'b0));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0000, 1'b1));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0004, 1'b1));
    steps.push_back(mkT(C_RDY, 32'h0, 32'h0, 32'h0000_0008, 1'b1, 1'b0, 32'h0, 2'd0));
    for (int i = 0; i < steps.size(); i++) begin
      applyStimulus(steps[i]);
      expQ.push_back(steps[i]);
      tick();
      e = expQ.pop_front();
      checkCount++;
      if ({bus.fetch_valid, bus.pc} !== {e.xValid, e.xPc})
        $display("[TB] FAIL boot[%0d] valid/pc got %b/%h want %b/%h", i, bus.fetch_valid, bus.pc, e.xValid, e.xPc);
      else passCount++;
      if (e.xFull) begin
        checkCount++;
        if ({bus.trap_taken, bus.epc, bus.cause} !== {e.xTrap, e.xEpc, e.xCause})
          $display("[TB] FAIL boot[%0d] trap/epc/cause got %b/%h/%0d want %b/%h/%0d", i, bus.trap_taken, bus.epc, bus.cause, e.xTrap, e.xEpc, e.xCause);
        else passCount++;
      end
    end
  endtask

  task automatic test_redirect();
    step_t steps[$];
    step_t e;
    steps.push_back(mk(C_RDY | C_JR, 32'h0, 32'h0000_0010, 32'h0000_0010, 1'b1));
    steps.push_back(mk(C_RDY | C_BR, 32'hFFFF_FFF8, 32'h0, 32'h0000_0008, 1'b1));
    steps.push_back(mkT(C_RDY | C_JR, 32'h0, 32'h0000_0101, 32'h0000_0100, 1'b1, 1'b0, 32'h0, 2'd0));
    steps.push_back(mk(C_RDY | C_JMP, 32'h0000_0010, 32'h0, 32'h0000_0110, 1'b1));
    steps.push_back(mk(C_RDY | C_JR | C_JMP | C_BR, 32'h4, 32'h0000_0200, 32'h0000_0204, 1'b1));
    steps.push_back(mk(C_RDY | C_JMP | C_BR, 32'h0000_0020, 32'h0, 32'h0000_0224, 1'b1));
    for (int i = 0; i < steps.size(); i++) begin
      applyStimulus(steps[i]);
      expQ.push_back(steps[i]);
      tick();
      e = expQ.pop_front();
      checkCount++;
      if ({bus.fetch_valid, bus.pc} !== {e.xValid, e.xPc})
        $display("[TB] FAIL redirect[%0d] valid/pc got %b/%h want %b/%h", i, bus.fetch_valid, bus.pc, e.xValid, e.xPc);
      else passCount++;
      if (e.xFull) begin
        checkCount++;
        if ({bus.trap_taken, bus.epc, bus.cause} !== {e.xTrap, e.xEpc, e.xCause})
          $display("[TB] FAIL redirect[%0d] trap/epc/cause got %b/%h/%0d want %b/%h/%0d", i, bus.trap_taken, bus.epc, bus.cause, e.xTrap, e.xEpc, e.xCause);
        else passCount++;
      end
    end
  endtask

  task automatic test_hold();
    step_t steps[$];
    step_t e;
    steps.push_back(mk(C_RDY | C_JR, 32'h0, 32'h0000_0020, 32'h0000_0020, 1'b1));
    steps.push_back(mk(C_BR, 32'h0000_0040, 32'h0, 32'h0000_0020, 1'b1));
    steps.push_back(mk(8'h00, 32'h0, 32'h0, 32'h0000_0020, 1'b1));
    steps.push_back(mk(8'h00, 32'h0, 32'h0, 32'h0000_0020, 1'b1));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0024, 1'b1));
    steps.push_back(mk(C_RDY | C_STL | C_JMP, 32'h0000_0040, 32'h0, 32'h0000_0024, 1'b1));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0028, 1'b1));
    for (int i = 0; i < steps.size(); i++) begin
      applyStimulus(steps[i]);
      expQ.push_back(steps[i]);
      tick();
      e = expQ.pop_front();
      checkCount++;
      if ({bus.fetch_valid, bus.pc} !== {e.xValid, e.xPc})
        $display("[TB] FAIL hold[%0d] valid/pc got %b/%h want %b/%h", i, bus.fetch_valid, bus.pc, e.xValid, e.xPc);
      else passCount++;
    end
  endtask

  task automatic test_misaligned();
    step_t steps[$];
    step_t e;
    steps.push_back(mk(C_RDY | C_JR, 32'h0, 32'h0000_0040, 32'h0000_0040, 1'b1));
    steps.push_back(mkT(C_RDY | C_JMP, 32'h2, 32'h0, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0040, 2'd2));
    steps.push_back(mkT(C_RDY, 32'h0, 32'h0, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0040, 2'd2));
    steps.push_back(mkT(C_RDY | C_BR, 32'h1, 32'h0, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0104, 2'd2));
    steps.push_back(mkT(C_RDY | C_JR, 32'h0, 32'h0000_0103, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0100, 2'd2));
    steps.push_back(mkT(C_JMP, 32'h2, 32'h0, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0100, 2'd2));
    for (int i = 0; i < steps.size(); i++) begin
      applyStimulus(steps[i]);
      expQ.push_back(steps[i]);
      tick();
      e = expQ.pop_front();
      checkCount++;
      if ({bus.fetch_valid, bus.pc} !== {e.xValid, e.xPc})
        $display("[TB] FAIL misalign[%0d] valid/pc got %b/%h want %b/%h", i, bus.fetch_valid, bus.pc, e.xValid, e.xPc);
      else passCount++;
      if (e.xFull) begin
        checkCount++;
        if ({bus.trap_taken, bus.epc, bus.cause} !== {e.xTrap, e.xEpc, e.xCause})
          $display("[TB] FAIL misalign[%0d] trap/epc/cause got %b/%h/%0d want %b/%h/%0d", i, bus.trap_taken, bus.epc, bus.cause, e.xTrap, e.xEpc, e.xCause);
        else passCount++;
      end
    end
  endtask

  task automatic test_halt_trap();
    step_t steps[$];
    step_t e;
    steps.push_back(mk(C_RDY | C_JR, 32'h0, 32'h0000_0030, 32'h0000_0030, 1'b1));
    steps.push_back(mk(C_RDY | C_HLT, 32'h0, 32'h0, 32'h0000_0034, 1'b0));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0034, 1'b0));
    steps.push_back(mk(C_RDY | C_JMP, 32'h0000_0040, 32'h0, 32'h0000_0034, 1'b0));
    steps.push_back(mkT(C_TRP, 32'h0, 32'h0, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0034, 2'd1));
    steps.push_back(mkT(C_RDY, 32'h0, 32'h0, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0034, 2'd1));
    steps.push_back(mk(C_HLT, 32'h0, 32'h0, 32'h0000_0104, 1'b0));
    steps.push_back(mk(C_RES, 32'h0, 32'h0, 32'h0000_0104, 1'b1));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0108, 1'b1));
    steps.push_back(mkT(C_RDY | C_HLT | C_TRP, 32'h0, 32'h0, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0108, 2'd1));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0104, 1'b1));
    for (int i = 0; i < steps.size(); i++) begin
      applyStimulus(steps[i]);
      expQ.push_back(steps[i]);
      tick();
      e = expQ.pop_front();
      checkCount++;
      if ({bus.fetch_valid, bus.pc} !== {e.xValid, e.xPc})
        $display("[TB] FAIL halt[%0d] valid/pc got %b/%h want %b/%h", i, bus.fetch_valid, bus.pc, e.xValid, e.xPc);
      else passCount++;
      if (e.xFull) begin
        checkCount++;
        if ({bus.trap_taken, bus.epc, bus.cause} !== {e.xTrap, e.xEpc, e.xCause})
          $display("[TB] FAIL halt[%0d] trap/epc/cause got %b/%h/%0d want %b/%h/%0d", i, bus.trap_taken, bus.epc, bus.cause, e.xTrap, e.xEpc, e.xCause);
        else passCount++;
      end
    end
  endtask

  task automatic test_wrap();
    step_t steps[$];
    step_t e;
    steps.push_back(mk(C_RDY | C_JR, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0000, 1'b1));
    steps.push_back(mk(C_RDY | C_BR, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b1));
    for (int i = 0; i < steps.size(); i++) begin
      applyStimulus(steps[i]);
      expQ.push_back(steps[i]);
      tick();
      e = expQ.pop_front();
      checkCount++;
      if ({bus.fetch_valid, bus.pc} !== {e.xValid, e.xPc})
        $display("[TB] FAIL wrap[%0d] valid/pc got %b/%h want %b/%h", i, bus.fetch_valid, bus.pc, e.xValid, e.xPc);
      else passCount++;
    end
    applyStimulus(mk(8'h00, 32'h0, 32'h0, 32'h0, 1'b0));
    #1;
    checkCount++;
    if (bus.pc_link !== 32'h0000_0000)
      $display("[TB] FAIL pc_link_wrap got %h want 00000000", bus.pc_link);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    step_t steps[$];
    step_t e;
    rst = 1'b0;
    #2;
    expQ.push_back(mkT(8'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 2'd0));
    e = expQ.pop_front();
    checkCount++;
    if ({bus.fetch_valid, bus.pc, bus.trap_taken, bus.epc, bus.cause} !==
        {e.xValid, e.xPc, e.xTrap, e.xEpc, e.xCause})
      $display("[TB] FAIL reset_mid got v=%b pc=%h t=%b epc=%h c=%0d want v=0 pc=0 t=0 epc=0 c=0",
               bus.fetch_valid, bus.pc, bus.trap_taken, bus.epc, bus.cause);
    else passCount++;
    tick();
    rst = 1'b1;
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0000, 1'b0));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0000, 1'b1));
    steps.push_back(mk(C_RDY, 32'h0, 32'h0, 32'h0000_0004, 1'b1));
    for (int i = 0; i < steps.size(); i++) begin
      applyStimulus(steps[i]);
      expQ.push_back(steps[i]);
      tick();
      e = expQ.pop_front();
      checkCount++;
      if ({bus.fetch_valid, bus.pc} !== {e.xValid, e.xPc})
        $display("[TB] FAIL reboot[%0d] valid/pc got %b/%h want %b/%h", i, bus.fetch_valid, bus.pc, e.xValid, e.xPc);
      else passCount++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d passed=%0d", checkCount, passCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_redirect();
    test_hold();
    test_misaligned();
    test_halt_trap();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the fixed 32-bit PC-plus-4 / PC-plus-immediate counter. It adds:
- absolute (register-relative) jumps,
- a fetch valid/ready handshake with stall,
- halt/resume control,
- trap redirection with a saved exception PC and cause.

It sits between the control unit/ALU and instruction memory, and is the single owner of the architectural PC.

## Interface
- XLEN, 32, address/data width
- RESET_VECTOR, 0, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on any trap
- IALIGN, 32, instruction alignment in bits (32 or 16); targets not aligned to IALIGN/8 bytes raise a misaligned trap
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- fetch_ready  in  1  instruction memory accepts pc this cycle
- stall  in  1  hold PC; suppresses acceptance
- branch_taken  in  1  redirect to pc + imm
- jump  in  1  redirect to pc + imm (JAL)
- jalr  in  1  redirect to (rs1 + imm) with bit 0 cleared
- imm  in  XLEN  sign-extended immediate
- rs1  in  XLEN  register operand for jalr
- halt_req  in  1  request halt
- resume  in  1  leave HALT
- trap_req  in  1  external trap/interrupt request
- pc  out  XLEN  current fetch address
- fetch_valid  out  1  pc is valid for fetch
- pc_link  out  XLEN  pc + 4, used for the link register
- trap_taken  out  1  one-cycle pulse when a trap redirect occurs
- epc  out  XLEN  PC of the instruction at which the trap occurred
- cause  out  2  0 none, 1 external, 2 misaligned target

## Operation
- States:
  - BOOT: one cycle after reset release; fetch_valid=0.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0; pc is held.
- Transitions:
  - BOOT→RUN unconditionally.
  - RUN→HALT on halt_req at acceptance, or on halt_req while idle.
  - HALT→RUN on resume.
  - trap_req in RUN or HALT→RUN at TRAP_VECTOR.
- Acceptance means fetch_valid && fetch_ready && !stall.
  - Redirect inputs (branch_taken, jump, jalr) are sampled only on acceptance.
  - Redirect inputs are ignored in any other cycle.
- Next-PC priority, highest first:
  1. rst
  2. trap_req (epc←pc, cause←1)
  3. misaligned redirect target (epc←pc, cause←2, pc←TRAP_VECTOR)
  4. jalr
  5. jump
  6. branch_taken
  7. acceptance, pc←pc+4
  8. otherwise hold
- Arithmetic: all sums are modulo 2^XLEN. pc=2^XLEN−4 with +4 wraps to 0. No overflow flag.
- Misaligned test:
  - IALIGN=32: target[1:0]≠0.
  - IALIGN=16: target[0]≠0, evaluated after the jalr bit-0 clear (so jalr never misaligns in 16-bit mode).
- pc_link is combinational pc+4.
- epc and cause persist until the next trap.
- halt_req and trap_req together: trap wins; state becomes RUN.

## Timing
- Reset values: pc=RESET_VECTOR, fetch_valid=0, trap_taken=0, epc=0, cause=0, state=BOOT.
- Reset is applied asynchronously; release is taken at the next clk edge.
- First valid fetch: fetch_valid=1 with pc=RESET_VECTOR on the second rising edge after reset release.
- Redirect latency is one cycle: the target appears on pc in the cycle after acceptance.
- trap_taken is high the cycle after the trap is sampled, together with pc=TRAP_VECTOR.
- While fetch_ready=0 or stall=1, pc and fetch_valid must remain stable; this is a valid/ready hold rule.
- Reset asserted mid-operation returns all outputs to their reset values immediately.

## Structure
- Package pc_pkg holds:
  - the pc_state_t enum (BOOT, RUN, HALT),
  - the pc_cause_t enum (NONE, EXT, MISALIGN),
  - the localparam ILEN_BYTES=4.
- Sub-module pc_target_calc is combinational. It produces the branch/jump target, the jalr target with bit-0 clear, and the misaligned flag, all parametrised by XLEN and IALIGN.
- The top level holds the state register, pc register, epc/cause registers, and the priority mux.

## Test plan
- Reset release, fetch_ready=1: fetch_valid rises on the 2nd edge with pc=0, then pc=4, then 8.
- Branch at pc=0x10, imm=−8, accepted: next pc=0x08. jalr with rs1=0x101, imm=0: next pc=0x100.
- fetch_ready=0 for 3 cycles at pc=0x20, with branch_taken pulsed in cycle 1: pc stays 0x20 and the branch is ignored; pc becomes 0x24 after ready.
- jump with imm=2 from pc=0x40, IALIGN=32: pc=0x100, trap_taken pulse, epc=0x40, cause=2.
- halt_req at pc=0x30 → fetch_valid=0 and pc=0x34 held. trap_req while halted → pc=0x100, epc=0x34, cause=1, state RUN.
- pc=0xFFFF_FFFC accepted: pc wraps to 0. Reset asserted mid-stream: pc=RESET_VECTOR and fetch_valid=0 immediately.
